// File: rtl/ap_job_ctrl_if.sv
// AP control/load/readback pin bundle between the job sequencer and one AP instance.
// The master is the sequencer, which owns the AP control pins. The slave is the AP array.
interface ap_job_ctrl_if #(
  parameter int AW = 10
);
  logic          ap_rst;
  logic          ap_mode;
  logic [2:0]    ap_cmd;
  logic          ap_write_en;
  logic          ap_sel_col;
  logic [7:0]    ap_data;
  logic [AW-1:0] ap_addr;
  logic [7:0]    ap_data_out;
  logic          ap_irq;

  modport master (
    output ap_rst, ap_mode, ap_cmd, ap_write_en, ap_sel_col, ap_data, ap_addr,
    input  ap_data_out, ap_irq
  );

  modport slave (
    input  ap_rst, ap_mode, ap_cmd, ap_write_en, ap_sel_col, ap_data, ap_addr,
    output ap_data_out, ap_irq
  );
endinterface

// File: rtl/ap_job_ctrl.sv
// Host-side job sequencer for the associative processor. It loads operand pairs, re-arms and runs
// the compute pass under a watchdog, then streams the selected column back out.
//
// state  | meaning
// IDLE   | waiting for a job; job_ready high
// LOAD   | waiting for an operand pair; ld_ready high
// WR_A   | column A write on the AP pins; column B write is queued
// WR_B   | column B write on the AP pins; advance or finish the load
// ARM    | one-cycle AP reset that clears its sticky DONE state
// RUN    | ap_mode high; waiting for ap_irq, or for the watchdog to expire
// READ   | streaming column words; rd_data comes straight from ap_data_out
module ap_job_ctrl #(
  parameter int  ROWS           = 1024,
  parameter int  TIMEOUT_CYCLES = 128,
  localparam int AW             = $clog2(ROWS),
  localparam int LW             = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_valid,
  output logic          job_ready,
  input  logic [LW-1:0] job_len,
  input  logic [2:0]    job_cmd,
  input  logic          job_rd_col,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_a,
  input  logic [7:0]    ld_b,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [7:0]    rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic          done,
  output logic          err,
  ap_job_ctrl_if.master ap
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WR_A = 3'd2;
  localparam logic [2:0] S_WR_B = 3'd3;
  localparam logic [2:0] S_ARM  = 3'd4;
  localparam logic [2:0] S_RUN  = 3'd5;
  localparam logic [2:0] S_READ = 3'd6;

  localparam int            WW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);
  localparam logic [LW-1:0] ROWS_L = LW'(ROWS);

  logic [2:0]    state;
  logic [AW-1:0] idx;
  logic [LW-1:0] len;
  logic [2:0]    cmd_q;
  logic          rd_col_q;
  logic [7:0]    b_q;
  logic [WW-1:0] wd;
  logic          rst_pulse;
  logic          mode_q;
  logic [2:0]    cmd_out;
  logic          we_q;
  logic          sel_q;
  logic [7:0]    data_q;
  logic [AW-1:0] addr_q;
  logic          done_q;
  logic          err_q;

  logic          idx_last;
  logic [WW-1:0] wd_inc;
  logic          wd_expired;

  // idx+1 is compared in LW bits, so a full ROWS-long job cannot wrap to zero.
  assign idx_last   = ({1'b0, idx} + LW'(1)) == len;
  assign wd_inc     = (wd == WD_MAX) ? wd : wd + 1'b1;
  assign wd_expired = (wd_inc == WD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      len       <= '0;
      cmd_q     <= '0;
      rd_col_q  <= 1'b0;
      b_q       <= '0;
      wd        <= '0;
      rst_pulse <= 1'b0;
      mode_q    <= 1'b0;
      cmd_out   <= '0;
      we_q      <= 1'b0;
      sel_q     <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rst_pulse <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            len      <= (job_len > ROWS_L) ? ROWS_L : job_len;
            cmd_q    <= job_cmd;
            rd_col_q <= job_rd_col;
            idx      <= '0;
            if (job_len == '0) err_q <= 1'b1;
            else               state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            b_q    <= ld_b;
            we_q   <= 1'b1;
            sel_q  <= 1'b0;
            addr_q <= idx;
            data_q <= ld_a;
            state  <= S_WR_A;
          end
        end
        S_WR_A: begin
          we_q   <= 1'b1;
          sel_q  <= 1'b1;
          data_q <= b_q;
          state  <= S_WR_B;
        end
        S_WR_B: begin
          if (idx_last) begin
            rst_pulse <= 1'b1;
            state     <= S_ARM;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_LOAD;
          end
        end
        S_ARM: begin
          wd      <= '0;
          mode_q  <= 1'b1;
          cmd_out <= cmd_q;
          state   <= S_RUN;
        end
        S_RUN: begin
          wd <= wd_inc;
          // A completion that lands on the expiry cycle still counts as a completion.
          if (ap.ap_irq) begin
            mode_q <= 1'b0;
            idx    <= '0;
            addr_q <= '0;
            sel_q  <= rd_col_q;
            state  <= S_READ;
          end else if (wd_expired) begin
            mode_q    <= 1'b0;
            err_q     <= 1'b1;
            rst_pulse <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_READ: begin
          if (rd_ready) begin
            if (idx_last) begin
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              idx    <= idx + 1'b1;
              addr_q <= idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign job_ready = (state == S_IDLE);
  assign ld_ready  = (state == S_LOAD);
  assign rd_valid  = (state == S_READ);
  assign rd_data   = rd_valid ? ap.ap_data_out : 8'h00;
  assign rd_last   = rd_valid & idx_last;
  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

  assign ap.ap_rst      = rst | rst_pulse;
  assign ap.ap_mode     = mode_q;
  assign ap.ap_cmd      = cmd_out;
  assign ap.ap_write_en = we_q;
  assign ap.ap_sel_col  = sel_q;
  assign ap.ap_data     = data_q;
  assign ap.ap_addr     = addr_q;

endmodule

// File: tb/tb_ap_job_ctrl.sv
// Randomized bench for ap_job_ctrl. A small behavioural AP stores the columns and raises a sticky irq.
// Expected writes and readback words come from per-job queues built from the job's operand list.
module tb_ap_job_ctrl;
  localparam int ROWS = 1024;
  localparam int TO   = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready, job_rd_col;
  logic [10:0] job_len;
  logic [2:0]  job_cmd;
  logic        ld_valid, ld_ready;
  logic [7:0]  ld_a, ld_b;
  logic        rd_valid, rd_ready, rd_last;
  logic [7:0]  rd_data;
  logic        busy, done, err;

  ap_job_ctrl_if #(.AW(10)) apb ();

  ap_job_ctrl #(.ROWS(ROWS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .job_cmd(job_cmd), .job_rd_col(job_rd_col),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_a(ld_a), .ld_b(ld_b),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done), .err(err),
    .ap(apb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural AP: column storage, combinational read, irq after irq_delay compute cycles (0 = never).
  logic [7:0] mem_a [ROWS];
  logic [7:0] mem_b [ROWS];
  int   irq_delay = 0;
  int   irq_cnt = 0;
  logic irq_q = 1'b0;

  always @(posedge clk) begin
    if (apb.ap_write_en) begin
      if (apb.ap_sel_col) mem_b[apb.ap_addr] <= apb.ap_data;
      else                mem_a[apb.ap_addr] <= apb.ap_data;
    end
    if (apb.ap_rst) begin
      irq_cnt <= 0;
      irq_q   <= 1'b0;
    end else if (apb.ap_mode) begin
      irq_cnt <= irq_cnt + 1;
      if (irq_delay != 0 && irq_cnt + 1 >= irq_delay) irq_q <= 1'b1;
    end
  end

  assign apb.ap_irq      = irq_q;
  assign apb.ap_data_out = apb.ap_sel_col ? mem_b[apb.ap_addr] : mem_a[apb.ap_addr];

  typedef struct packed {
    logic [9:0] addr;
    logic       col;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [8:0] exp_rd[$];
  logic [7:0] pa [ROWS];
  logic [7:0] pb [ROWS];

  int done_cnt = 0, err_cnt = 0, mode_cyc = 0, aprst_cyc = 0, rdv_cyc = 0, acc_cnt = 0, rd_words = 0;
  logic       arm_prev = 0, wa_prev = 0, stall_prev = 0, last_hs_prev = 0, done_prev = 0;
  logic [9:0] wa_addr;
  logic [7:0] stall_data;
  logic       stall_last;
  wr_t        w;
  logic [8:0] e;

  always @(negedge clk) begin
    if (rst) begin
      arm_prev = 0; wa_prev = 0; stall_prev = 0; last_hs_prev = 0; done_prev = 0;
    end else begin
      if (job_valid && job_ready) acc_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (apb.ap_mode) mode_cyc++;
      if (apb.ap_rst) aprst_cyc++;
      if (rd_valid) rdv_cyc++;
      check("inv_we_mode", apb.ap_write_en & apb.ap_mode, 0);
      check("inv_ready_busy", job_ready & busy, 0);
      if (apb.ap_rst) begin
        check("arm_mode_low", apb.ap_mode, 0);
        check("aprst_context", busy | err, 1);
      end
      if (arm_prev) check("mode_after_arm", apb.ap_mode, 1);
      if (apb.ap_write_en) begin
        check("wr_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          check("wr_addr", apb.ap_addr, w.addr);
          check("wr_col", apb.ap_sel_col, w.col);
          check("wr_data", apb.ap_data, w.data);
        end
      end
      if (wa_prev) check("wr_b_follows_a", {apb.ap_write_en, apb.ap_sel_col, apb.ap_addr}, {2'b11, wa_addr});
      if (stall_prev && rd_valid) begin
        check("rd_hold_data", rd_data, stall_data);
        check("rd_hold_last", rd_last, stall_last);
      end
      if (last_hs_prev) check("done_after_last", done, 1);
      if (done) check("done_one_cycle", done_prev, 0);
      if (rd_valid && rd_ready) begin
        rd_words++;
        check("rd_expected", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) begin
          e = exp_rd.pop_front();
          check("rd_data", rd_data, e[7:0]);
          check("rd_last", rd_last, e[8]);
        end
      end
      arm_prev     = apb.ap_rst && busy;
      wa_prev      = apb.ap_write_en && !apb.ap_sel_col;
      wa_addr      = apb.ap_addr;
      stall_prev   = rd_valid && !rd_ready;
      stall_data   = rd_data;
      stall_last   = rd_last;
      last_hs_prev = rd_valid && rd_ready && rd_last;
      done_prev    = done;
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic start_job(input int len, input logic [2:0] cmd, input logic col, input bit hold);
    int guard = 0;
    bit hs = 0;
    job_valid  = 1'b1;
    job_len    = len[10:0];
    job_cmd    = cmd;
    job_rd_col = col;
    while (!hs && guard < 20000) begin
      hs = job_ready;
      @(posedge clk); #1;
      guard++;
    end
    check("job_accept", hs, 1);
    if (!hold) job_valid = 1'b0;
  endtask

  task automatic load_phase(input int len, input logic col, input bit rnd_v, input bit fill);
    int eff = (len > ROWS) ? ROWS : len;
    int i = 0;
    int guard = 0;
    bit hs;
    for (int k = 0; k < eff; k++) begin
      if (fill) begin
        pa[k] = 8'($urandom);
        pb[k] = 8'($urandom);
      end
      exp_wr.push_back('{addr: 10'(k), col: 1'b0, data: pa[k]});
      exp_wr.push_back('{addr: 10'(k), col: 1'b1, data: pb[k]});
      exp_rd.push_back({(k == eff - 1), (col ? pb[k] : pa[k])});
    end
    while (i < eff && guard < eff * 20 + 100) begin
      ld_valid = rnd_v ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_a = pa[i];
      ld_b = pb[i];
      hs = ld_valid && ld_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    ld_valid = 1'b0;
    check("load_all_pairs", i, eff);
  endtask

  task automatic finish_phase(input int stall_at, input bit rnd_r, output bit got_done, output bit got_err);
    int guard = 0;
    int stalls = 0;
    got_done = 0;
    got_err = 0;
    while (!got_done && !got_err && guard < 20000) begin
      if (stall_at >= 0 && rd_words == stall_at && stalls < 5 && rd_valid) begin
        rd_ready = 1'b0;
        stalls++;
      end else begin
        rd_ready = rnd_r ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(posedge clk); #1;
      guard++;
      if (done) got_done = 1;
      if (err) got_err = 1;
    end
    rd_ready = 1'b0;
    check("job_terminated", got_done | got_err, 1);
    if (stall_at >= 0) check("stall_applied", stalls, 5);
  endtask

  task automatic run_job(input int len, input logic [2:0] cmd, input logic col, input int irq_d,
                         input bit rnd_v, input bit rnd_r, input int stall_at, input bit fill);
    int d0 = done_cnt, e0 = err_cnt, m0 = mode_cyc, r0 = aprst_cyc, v0 = rdv_cyc;
    bit gd, ge;
    irq_delay = irq_d;
    rd_words = 0;
    start_job(len, cmd, col, 0);
    if (len == 0) begin
      repeat (3) @(posedge clk);
      #1;
      check("len0_err", err_cnt - e0, 1);
      check("len0_idle", busy, 0);
      check("len0_no_run", mode_cyc - m0, 0);
      return;
    end
    load_phase(len, col, rnd_v, fill);
    finish_phase(stall_at, rnd_r, gd, ge);
    @(posedge clk); #1;
    if (irq_d == 0) begin
      check("to_err_once", err_cnt - e0, 1);
      check("to_no_done", done_cnt - d0, 0);
      check("to_run_cycles", mode_cyc - m0, TO);
      check("to_aprst_cycles", aprst_cyc - r0, 2);
      check("to_no_rd_valid", rdv_cyc - v0, 0);
      check("to_mode_low", apb.ap_mode, 0);
      check("to_job_ready", job_ready, 1);
      exp_rd.delete();
    end else begin
      check("done_once", done_cnt - d0, 1);
      check("no_err", err_cnt - e0, 0);
      check("arm_once", aprst_cyc - r0, 1);
      check("rd_words", rd_words, (len > ROWS) ? ROWS : len);
      check("rd_queue_drained", exp_rd.size(), 0);
      check("job_ready_after", job_ready, 1);
    end
    check("wr_queue_drained", exp_wr.size(), 0);
  endtask

  initial begin
    int d0, e0, a0;
    bit gd, ge;
    rst = 1'b1;
    job_valid = 0; job_len = 0; job_cmd = 0; job_rd_col = 0;
    ld_valid = 0; ld_a = 0; ld_b = 0; rd_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_job_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_ap_pins", {apb.ap_mode, apb.ap_write_en, apb.ap_sel_col, apb.ap_cmd, apb.ap_addr, apb.ap_data}, 0);
    check("rst_ap_rst_high", apb.ap_rst, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ap_rst_released", apb.ap_rst, 0);

    pa[0] = 8'h01; pb[0] = 8'h02;
    pa[1] = 8'h10; pb[1] = 8'h20;
    pa[2] = 8'hFF; pb[2] = 8'h00;
    pa[3] = 8'h0F; pb[3] = 8'hF0;
    run_job(4, 3'd0, 1'b0, 10, 0, 0, -1, 0);

    run_job(16, 3'd5, 1'b1, 7, 1, 1, 6, 1);
    run_job(5, 3'd2, 1'b0, 0, 1, 0, -1, 1);
    run_job(0, 3'd1, 1'b0, 4, 0, 0, -1, 1);
    run_job(1, 3'd3, 1'b1, 3, 0, 0, -1, 1);
    run_job(2047, 3'd4, 1'b0, 5, 0, 0, -1, 1);

    // Reset in the middle of RUN abandons the job without done or err.
    irq_delay = 0;
    start_job(3, 3'd0, 1'b0, 0);
    load_phase(3, 1'b0, 0, 1);
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_running", apb.ap_mode, 1);
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_ap_rst", apb.ap_rst, 1);
    @(posedge clk); #1;
    check("mid_rst_mode", apb.ap_mode, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_job_ready", job_ready, 1);
    rst = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_pulse", {done_cnt - d0, err_cnt - e0}, 0);
    run_job(6, 3'd6, 1'b1, 9, 1, 1, -1, 1);

    // Second job held on job_valid through the first; accepted only after done.
    irq_delay = 20;
    d0 = done_cnt; a0 = acc_cnt;
    rd_words = 0;
    start_job(3, 3'd1, 1'b0, 1);
    job_len = 11'd5; job_cmd = 3'd2; job_rd_col = 1'b1;
    load_phase(3, 1'b0, 1, 1);
    finish_phase(-1, 0, gd, ge);
    check("b2b_first_done", gd, 1);
    check("b2b_single_accept", acc_cnt - a0, 1);
    check("b2b_ready_with_done", job_ready, 1);
    rd_words = 0;
    start_job(5, 3'd2, 1'b1, 0);
    check("b2b_second_accept", acc_cnt - a0, 2);
    load_phase(5, 1'b1, 0, 1);
    finish_phase(-1, 1, gd, ge);
    @(posedge clk); #1;
    check("b2b_done_twice", done_cnt - d0, 2);
    check("b2b_rd_words", rd_words, 5);
    check("b2b_rd_drained", exp_rd.size(), 0);

    for (int k = 0; k < 4; k++)
      run_job($urandom_range(1, 40), 3'($urandom), 1'($urandom), $urandom_range(1, 60), 1, 1, -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/ap_job_ctrl.md
Name: ap_job_ctrl

Overview:
Host-side sequencer for the 2D associative processor (AP) array. It accepts one job at a time and streams operand pairs into AP columns A and B through the AP load port. It then re-arms and runs the AP bit-serial compute pass, waits for the AP completion IRQ under a watchdog, and streams the selected column back out. It sits between the system bus/DMA streams and a single AP instance, and is the only master of the AP control pins.

Parameters:
ROWS, 1024, AP row count; addresses 0..ROWS-1.
TIMEOUT_CYCLES, 128, maximum RUN cycles before ap_irq is declared lost.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
job_valid  in  1  job request
job_ready  out  1  controller can accept a job
job_len  in  11  number of rows to load/read, 1..ROWS
job_cmd  in  3  AP opcode forwarded to ap_cmd
job_rd_col  in  1  readback column: 0=A, 1=B
ld_valid  in  1  operand pair valid
ld_ready  out  1  operand pair accepted
ld_a  in  8  operand for column A
ld_b  in  8  operand for column B
rd_valid  out  1  readback word valid
rd_ready  in  1  downstream accepts readback
rd_data  out  8  readback word
rd_last  out  1  marks final readback word
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a job completes
err  out  1  one-cycle pulse on timeout or a bad job_len
ap_rst  out  1  AP synchronous reset
ap_mode  out  1  AP compute enable
ap_cmd  out  3  AP opcode
ap_write_en  out  1  AP load write strobe
ap_sel_col  out  1  AP column select, 0=A, 1=B
ap_data  out  8  AP write data
ap_addr  out  10  AP row address
ap_data_out  in  8  AP combinational read data
ap_irq  in  1  AP done level

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE. job_ready=1; every other output is 0, including all AP-side registers and the counters. ap_rst = rst OR internal arm pulse, so the AP is held in reset while rst is high.
- Reset mid-job: the job is abandoned. No done/err pulse is issued. AP column contents are unspecified afterwards.
- IDLE: job_ready=1.
  - On job_valid&&job_ready, latch len/cmd/rd_col and clear idx.
  - job_len=0: pulse err next cycle and stay in IDLE.
  - job_len>ROWS: clamp to ROWS.
  - Otherwise go to LOAD_A.
- LOAD_A: ld_ready=1. On handshake in cycle t, latch ld_b. Every AP-side output is registered.
  - t+1 (WR_A): ap_write_en=1, ap_sel_col=0, ap_addr=idx, ap_data=ld_a.
  - t+2 (WR_B): ap_write_en=1, ap_sel_col=1, ap_addr=idx, ap_data=latched b.
  - Throughput is 3 cycles per pair; ld_ready=0 outside LOAD_A.
  - After WR_B: if idx==len-1 go to ARM, else idx+1 and return to LOAD_A.
- ARM: exactly one cycle, with ap_rst=1 and ap_mode=0. This re-arms the AP FSM, whose DONE state is sticky until reset. Clear the watchdog, then go to RUN.
- RUN: ap_mode=1, ap_cmd=latched cmd, ap_write_en=0. The watchdog increments every cycle.
  - ap_irq==1 sampled: ap_mode=0 next cycle; clear idx; go to READ.
  - Watchdog reaches TIMEOUT_CYCLES with no irq: ap_mode=0, one-cycle err pulse, one-cycle ap_rst pulse, return to IDLE.
  - irq and timeout in the same cycle: irq wins.
- READ: ap_mode=0, ap_sel_col=rd_col, ap_addr=idx.
  - rd_valid=1 and rd_data=ap_data_out, a combinational path through the AP.
  - rd_last=(idx==len-1).
  - While rd_ready=0, idx holds, so rd_data and rd_last stay stable.
  - On rd_valid&&rd_ready: if rd_last, pulse done next cycle and go to IDLE; otherwise idx+1.
- Invariants:
  - ap_write_en and ap_mode are never high together.
  - ap_rst is only high in ARM, on timeout recovery, or during rst.
  - job_ready=0 whenever busy=1; a new job cannot preempt the current one.
- Widths: idx is 10 bits and len is 11 bits; compare idx+1 against len in 11 bits, with no wrap. The watchdog is clog2(TIMEOUT_CYCLES+1) bits and saturates.

Test Plan:
- Full OR job: job_len=4, cmd=0, rd_col=0, pairs (a,b)=(01,02),(10,20),(FF,00),(0F,F0).
  - AP sees 8 writes at addr 0..3: A first, then B, 3 cycles per pair.
  - One ARM cycle has ap_rst=1, then ap_mode rises; after ap_irq, readback returns 01,10,FF,0F.
  - rd_last is set on the 4th word and done pulses once.
- Backpressure:
  - Toggle ld_valid randomly: no pair is lost or duplicated, and AP write addresses stay contiguous.
  - Hold rd_ready=0 for 5 cycles mid-read: rd_data and rd_last stay stable and idx does not advance.
- Timeout: tie ap_irq=0.
  - After 128 RUN cycles: err pulses once, ap_mode=0, one ap_rst pulse, back in IDLE with job_ready=1, and no rd_valid ever.
- Edge lengths:
  - job_len=0: err pulse, no AP writes.
  - job_len=1: a single pair, and the first readback word has rd_last=1.
  - job_len=2047: clamps to 1024, so addresses run 0..1023 with no wrap.
- Reset mid-run: assert rst for 1 cycle during RUN.
  - Next cycle: ap_mode=0, busy=0, job_ready=1, no done/err pulse, ap_rst=1 while rst is high.
  - A subsequent job completes normally.
- Back-to-back jobs: a second job_valid is held high through the first job.
  - It is accepted only after the done pulse.
  - Its ARM cycle re-arms the AP and ap_irq re-occurs; readback uses the new rd_col=1.
